alu_serial: RTL and testbench

//  Multi-cycle, slice-serial ALU for operands wider than the 4-bit combinational ALU datapath.

---
 rtl/alu_serial.sv | 175 +++++++++++++++++
 tb/tb_alu_serial.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// alu_serial: slice-serial ALU. Operands are processed SLICE bits per clock,
// LSB slice first, with the carry rippled between slices through a register.
// The result, carry_out and zero flag are committed together when the last
// slice finishes. carry_out is kept between operations so that multi-word
// arithmetic can be chained.
module alu_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       cmd,
    input  logic             chain,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry_out,
    output logic             zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Reject parameter combinations that cannot be split into whole slices.
    generate
        if ((SLICE < 1) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
            $error("alu_serial: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;

    // Operand A and the pre-inverted operand B are shifted right one slice per
    // clock, so the active slice always sits at bit 0. bx_q carries one extra
    // top bit holding cin0: it becomes the right-shift fill of the MSB.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH:0]   bx_q;
    logic             cd_q;
    logic [1:0]       sel_q;
    logic             carry_q;
    logic [CW-1:0]    slice_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] res_q;
    logic             cout_q;
    logic             zero_q;

    logic             accept;
    logic             cin0;
    logic             last_slice;
    logic [SLICE:0]   c_w;
    logic [SLICE-1:0] sres_w;
    logic [WIDTH-1:0] acc_d;

    assign accept     = in_valid && (state_q == S_IDLE);
    assign cin0       = chain ? cout_q : cmd[4];
    assign last_slice = (slice_q == CW'(N - 1));
    assign c_w[0]     = carry_q;

    // Per-bit datapath of the active slice: generate/propagate carry chain and
    // the sel-driven result mux, with the carry term optionally suppressed.
    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
            logic bp;
            logic rb;
            logic g;
            logic p;
            logic m;
            assign bp            = bx_q[gi];
            assign rb            = bx_q[gi+1];
            assign g             = a_q[gi] & bp;
            assign p             = a_q[gi] | bp;
            assign m             = sel_q[1] ? (sel_q[0] ? rb : p)
                                            : (sel_q[0] ? g  : (~g & p));
            assign c_w[gi+1]     = g | (p & c_w[gi]);
            assign sres_w[gi]    = m ^ (c_w[gi] & ~cd_q);
        end

        // Finished slices enter the accumulator from the top so that after N
        // slices the LSB slice has arrived at bit 0.
        if (N > 1) begin : g_acc_multi
            assign acc_d = {sres_w, acc_q[WIDTH-1:SLICE]};
        end else begin : g_acc_single
            assign acc_d = sres_w;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_slice) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand latch, per-slice iteration and result commit on the last slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            bx_q    <= '0;
            cd_q    <= 1'b0;
            sel_q   <= 2'b00;
            carry_q <= 1'b0;
            slice_q <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= d1;
            bx_q    <= {cin0, d2 ^ {WIDTH{cmd[3]}}};
            cd_q    <= cmd[2];
            sel_q   <= cmd[1:0];
            carry_q <= cin0;
            slice_q <= '0;
            acc_q   <= '0;
        end else if (state_q == S_RUN) begin
            a_q     <= a_q >> SLICE;
            bx_q    <= bx_q >> SLICE;
            carry_q <= c_w[SLICE];
            acc_q   <= acc_d;
            slice_q <= slice_q + CW'(1);
            if (last_slice) begin
                slice_q <= '0;
                res_q   <= acc_d;
                cout_q  <= c_w[SLICE];
                zero_q  <= (acc_d == '0);
            end
        end
    end

    assign res       = res_q;
    assign carry_out = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_serial.sv
// Testbench for alu_serial (WIDTH=16, SLICE=4): table of operations applied
// in order (carry chaining depends on it), expected results queued at accept
// and compared when out_valid appears, plus stall and mid-run reset sequences.
module tb_alu_serial;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int NSL   = WIDTH / SLICE;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       cmd;
    logic             chain;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             carry_out;
    logic             zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        z;
    } exp_t;

    typedef struct {
        logic [4:0]  cmd;
        logic        chain;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        z;
    } vec_t;

    exp_t sb[$];
    vec_t vt[16];

    alu_serial #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd       (cmd),
        .chain     (chain),
        .d1        (d1),
        .d2        (d2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .carry_out (carry_out),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // One complete transaction. Entered #1 after a rising edge with the DUT idle.
    task automatic run_op(input string name, input logic [4:0] c, input logic ch,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic ec, input logic ez,
                          input int stall);
        exp_t e;
        exp_t got;
        int   cyc;
        logic [15:0] hold_res;
        logic        hold_c;
        logic        hold_z;
        check({name, ".in_ready_idle"}, in_ready, 1);
        cmd      = c;
        chain    = ch;
        d1       = a;
        d2       = b;
        in_valid = 1'b1;
        e.res = er;
        e.c   = ec;
        e.z   = ez;
        sb.push_back(e);
        @(posedge clk); #1;
        // Scramble inputs: the DUT must work from its latched copies.
        in_valid = 1'b0;
        cmd      = 5'($urandom);
        chain    = 1'($urandom);
        d1       = 16'($urandom);
        d2       = 16'($urandom);
        check({name, ".in_ready_run"}, in_ready, 0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, ".latency"}, cyc, NSL);
        if (out_valid) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s.scoreboard: got out_valid, required no pending result", name);
            end else begin
                got = sb.pop_front();
                check({name, ".res"}, res, got.res);
                check({name, ".carry"}, carry_out, got.c);
                check({name, ".zero"}, zero, got.z);
            end
        end
        $display("op %s cmd=%b chain=%b a=%h b=%h -> res=%h c=%b z=%b lat=%0d",
                 name, c, ch, a, b, res, carry_out, zero, cyc);
        hold_res = res;
        hold_c   = carry_out;
        hold_z   = zero;
        for (int s = 0; s < stall; s++) begin
            // Offer a new command while busy: it must be ignored.
            in_valid = 1'b1;
            d1       = 16'($urandom);
            @(posedge clk); #1;
            check({name, ".stall_valid"}, out_valid, 1);
            check({name, ".stall_in_ready"}, in_ready, 0);
            check({name, ".stall_res"}, res, hold_res);
            check({name, ".stall_c"}, carry_out, hold_c);
            check({name, ".stall_z"}, zero, hold_z);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, ".released"}, out_valid, 0);
        check({name, ".back_idle"}, in_ready, 1);
    endtask

    initial begin
        int seen_valid;
        vt[0]  = '{5'b00000, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0}; // ADD
        vt[1]  = '{5'b11000, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0}; // SUB borrow
        vt[2]  = '{5'b11000, 1'b0, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0}; // SUB
        vt[3]  = '{5'b01000, 1'b0, 16'h1234, 16'h1233, 16'h0000, 1'b1, 1'b1}; // COMP A>B
        vt[4]  = '{5'b01000, 1'b0, 16'h1233, 16'h1234, 16'hFFFE, 1'b0, 1'b0}; // COMP A<B
        vt[5]  = '{5'b00000, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1}; // ADD wrap
        vt[6]  = '{5'b00000, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0}; // chained ADD
        vt[7]  = '{5'b10111, 1'b0, 16'h0000, 16'h8001, 16'hC000, 1'b0, 1'b0}; // RSHFT fill 1
        vt[8]  = '{5'b00111, 1'b0, 16'h0000, 16'h8001, 16'h4000, 1'b0, 1'b0}; // RSHFT fill 0
        vt[9]  = '{5'b00101, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b1, 1'b0}; // AND
        vt[10] = '{5'b00110, 1'b0, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b1, 1'b0}; // OR
        vt[11] = '{5'b00100, 1'b0, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b1, 1'b0}; // XOR
        vt[12] = '{5'b01100, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3333, 1'b1, 1'b0}; // XNOR
        vt[13] = '{5'b00100, 1'b0, 16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b1}; // XOR equal
        vt[14] = '{5'b10000, 1'b0, 16'h8000, 16'h8000, 16'h0001, 1'b1, 1'b0}; // ADD cin=1
        vt[15] = '{5'b00000, 1'b1, 16'h0001, 16'h0002, 16'h0004, 1'b0, 1'b0}; // chained ADD

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cmd       = 5'b0;
        chain     = 1'b0;
        d1        = '0;
        d2        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", in_ready, 1);
        check("reset.out_valid", out_valid, 0);
        check("reset.res", res, 0);
        check("reset.carry", carry_out, 0);
        check("reset.zero", zero, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].cmd, vt[i].chain, vt[i].a, vt[i].b,
                   vt[i].res, vt[i].c, vt[i].z, 0);
        end

        // Consumer back-pressure: result held for 3 cycles, carry left set.
        run_op("stall", 5'b00000, 1'b0, 16'h8000, 16'h9000, 16'h1000, 1'b1, 1'b0, 3);

        // Reset in the middle of an operation.
        cmd      = 5'b00000;
        chain    = 1'b0;
        d1       = 16'h0001;
        d2       = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort.in_ready", in_ready, 1);
        check("abort.out_valid", out_valid, 0);
        check("abort.carry", carry_out, 0);
        check("abort.res", res, 0);
        check("abort.zero", zero, 0);
        seen_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid++;
        end
        check("abort.no_result", seen_valid, 0);
        $display("op abort: reset applied mid-run, out_valid seen %0d times", seen_valid);

        // Chained ADD after reset must start from a cleared carry.
        run_op("post_reset", 5'b00000, 1'b1, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 0);

        check("scoreboard.empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
